fifo_word_packer: RTL and testbench

Read-side engine for the team's 8-bit, 16-entry synchronous FIFO. It drains bytes through the FIFO read strobe and packs them, first byte in the LSB, into wide words. Each word is presented downstream on a valid/ready handshake. A flush request lets it emit a partial word with its byte count, so the packet tail is never stranded in the packer.

---
 rtl/fifo_word_packer_if.sv | 23 ++
 rtl/fifo_word_packer.sv | 59 +++++
 tb/tb_fifo_word_packer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if: FIFO read port, flush request and valid/ready word output of the packer.
interface fifo_word_packer_if #(
  parameter int BYTES = 4
) ();
  localparam int OW = 8 * BYTES;
  localparam int CW = $clog2(BYTES) + 1;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [7:0]    fifo_rdata;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_word;
  logic [CW-1:0] out_bytes;
  modport master (
    input  fifo_empty, fifo_rdata, flush, out_ready,
    output fifo_rd_en, out_valid, out_word, out_bytes
  );
  modport slave (
    output fifo_empty, fifo_rdata, flush, out_ready,
    input  fifo_rd_en, out_valid, out_word, out_bytes
  );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains an 8-bit FIFO and packs bytes LSB-first into words, with flush for partial words.
module fifo_word_packer #(
  parameter int BYTES = 4
) (
  input logic                clk,
  input logic                reset,
  fifo_word_packer_if.master bus
);
  localparam int OW = 8 * BYTES;
  localparam int CW = $clog2(BYTES) + 1;
  typedef enum logic {FILL, HOLD} state_t;
  state_t        r_state;
  logic [CW-1:0] r_count, r_out_bytes, w_cnt_nxt;
  logic          r_pending, r_flush_pend, r_out_valid;
  logic          w_rd_en, w_full, w_flush_done;
  logic [OW-1:0] r_slots, r_out_word, w_slots;
  assign w_cnt_nxt    = r_count + CW'(r_pending);
  assign w_full       = w_cnt_nxt == CW'(BYTES);
  assign w_flush_done = r_flush_pend && !r_pending;
  assign w_rd_en      = !reset && r_state == FILL && !bus.fifo_empty && !r_flush_pend && w_cnt_nxt < CW'(BYTES);
  always_comb begin
    w_slots = r_slots;
    for (int k = 0; k < BYTES; k++)
      if (r_pending && r_count == CW'(k)) w_slots[8*k +: 8] = bus.fifo_rdata;
  end
  // the in-flight byte is merged before the HOLD decision so a full word leaves one cycle after its last capture
  always_ff @(posedge clk)
    if (reset) begin
      r_state      <= FILL;
      r_count      <= '0;
      r_pending    <= 1'b0;
      r_flush_pend <= 1'b0;
      r_slots      <= '0;
      r_out_valid  <= 1'b0;
      r_out_word   <= '0;
      r_out_bytes  <= '0;
    end else if (r_state == FILL) begin
      r_pending    <= w_rd_en;
      r_slots      <= w_slots;
      r_count      <= w_cnt_nxt;
      r_flush_pend <= bus.flush || (r_flush_pend && !w_flush_done);
      if (w_full || (w_flush_done && r_count != '0)) begin
        r_state     <= HOLD;
        r_out_word  <= w_slots;
        r_out_bytes <= w_cnt_nxt;
        r_out_valid <= 1'b1;
      end
    end else if (bus.out_ready) begin
      r_state      <= FILL;
      r_out_valid  <= 1'b0;
      r_count      <= '0;
      r_slots      <= '0;
      r_flush_pend <= 1'b0;
    end
  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_word   = r_out_word;
  assign bus.out_bytes  = r_out_bytes;
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed vectors, corner sequences and random traffic against a byte-stream model.
module tb_fifo_word_packer;
  localparam int BYTES = 4;
  typedef struct {
    int          n;
    logic [31:0] d;
    logic [31:0] w;
    int          b;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fifo_word_packer_if #(.BYTES(BYTES)) bus ();
  fifo_word_packer #(.BYTES(BYTES)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int failures = 0;
  int rd_empty_err = 0;
  int stab_err = 0;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic s_rd, s_valid, s_ready, s_acc;
  logic [31:0] s_word;
  logic [2:0] s_bytes;
  logic prev_hold = 1'b0;
  logic [31:0] prev_word;
  logic [2:0] prev_bytes;
  logic flush_seen;
  vec_t vecs[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic push(input logic [7:0] b);
    q.push_back(b);
    exp_q.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask
  task automatic cyc();
    @(negedge clk);
    s_rd    = bus.fifo_rd_en;
    s_valid = bus.out_valid;
    s_ready = bus.out_ready;
    s_word  = bus.out_word;
    s_bytes = bus.out_bytes;
    s_acc   = s_valid && s_ready;
    if (s_rd && q.size() == 0) rd_empty_err++;
    if (prev_hold && (!s_valid || s_word != prev_word || s_bytes != prev_bytes)) stab_err++;
    prev_hold  = s_valid && !s_ready && !reset;
    prev_word  = s_word;
    prev_bytes = s_bytes;
    @(posedge clk);
    #1;
    if (s_rd && q.size() > 0) bus.fifo_rdata = q.pop_front();
    bus.fifo_empty = q.size() == 0;
    bus.flush = 1'b0;
  endtask
  task automatic wait_valid(input int lim, output int lat);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!s_valid && lat <= lim);
    chk("valid_seen", s_valid, 1);
  endtask
  task automatic rnd_cycle();
    logic [31:0] e;
    cyc();
    if (s_acc) begin
      e = '0;
      for (int k = 0; k < int'(s_bytes) && k < BYTES; k++)
        if (exp_q.size() > 0) e[8*k +: 8] = exp_q.pop_front();
      chk("rnd_word", s_word, e);
      chk("rnd_bytes_ok", s_bytes >= 1 && s_bytes <= BYTES && (s_bytes == BYTES || flush_seen), 1);
      flush_seen = 1'b0;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int lat, n;
    logic [7:0] rd_log, v_log;
    logic [31:0] w5;
    logic [2:0] b5;
    vecs[0] = '{1, 32'h99887A5A, 32'h0000005A, 1};
    vecs[1] = '{2, 32'h1234FF80, 32'h0000FF80, 2};
    vecs[2] = '{3, 32'hEE030201, 32'h00030201, 3};
    vecs[3] = '{4, 32'hDEADBEEF, 32'hDEADBEEF, 4};
    vecs[4] = '{4, 32'h00000000, 32'h00000000, 4};
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    cyc();
    chk("rd_en_during_reset", s_rd, 0);
    cyc();
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_word", bus.out_word, 0);
    chk("reset_bytes", bus.out_bytes, 0);
    reset = 1'b0;
    rd_log = '0; v_log = '0; w5 = '0; b5 = '0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      rd_log[k] = s_rd;
      v_log[k] = s_valid;
      if (k == 5) begin w5 = s_word; b5 = s_bytes; end
    end
    chk("t1_rd_en_cycles", rd_log, 8'b0000_1111);
    chk("t1_valid_cycles", v_log, 8'b0010_0000);
    chk("t1_word", w5, 32'h44332211);
    chk("t1_bytes", b5, 4);
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) push(8'(k));
    wait_valid(20, lat);
    chk("t2_first_word", s_word, 32'h04030201);
    n = 0;
    repeat (10) begin
      cyc();
      if (!s_valid || s_word != 32'h04030201 || s_rd) n++;
    end
    chk("t2_held_no_read", n, 0);
    bus.out_ready = 1'b1;
    cyc();
    chk("t2_accept", s_acc, 1);
    wait_valid(12, lat);
    chk("t2_second_word", s_word, 32'h08070605);
    chk("t2_second_bytes", s_bytes, 4);
    push(8'hA1); push(8'hA2); push(8'hA3);
    n = 0;
    repeat (8) begin
      cyc();
      if (s_valid) n++;
    end
    chk("t3_partial_persists", n, 0);
    bus.flush = 1'b1;
    cyc();
    wait_valid(10, lat);
    chk("t3_flush_latency", lat, 2);
    chk("t3_word", s_word, 32'h00A3A2A1);
    chk("t3_bytes", s_bytes, 3);
    push(8'hB1);
    repeat (4) cyc();
    push(8'hB2);
    bus.flush = 1'b1;
    cyc();
    chk("t4_strobe_with_flush", s_rd, 1);
    wait_valid(10, lat);
    chk("t4_flush_latency", lat, 3);
    chk("t4_word", s_word, 32'h0000B2B1);
    chk("t4_bytes", s_bytes, 2);
    repeat (4) cyc();
    bus.flush = 1'b1;
    n = 0;
    repeat (9) begin
      cyc();
      if (s_valid) n++;
    end
    chk("t5_empty_flush_no_word", n, 0);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    wait_valid(12, lat);
    chk("t5_latency", lat, 6);
    chk("t5_word", s_word, 32'h88776655);
    chk("t5_bytes", s_bytes, 4);
    push(8'hC1); push(8'hC2);
    repeat (5) cyc();
    push(8'hC3);
    cyc();
    chk("t6_strobe_before_reset", s_rd, 1);
    reset = 1'b1;
    cyc();
    chk("t6_rd_en_in_reset", s_rd, 0);
    chk("t6_reset_valid", bus.out_valid, 0);
    chk("t6_reset_word", bus.out_word, 0);
    chk("t6_reset_bytes", bus.out_bytes, 0);
    reset = 1'b0;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    wait_valid(12, lat);
    chk("t6_word_after_reset", s_word, 32'hD4D3D2D1);
    chk("t6_bytes_after_reset", s_bytes, 4);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vecs[i].n; k++) push(vecs[i].d[8*k +: 8]);
      if (vecs[i].n < BYTES) begin
        repeat (8) cyc();
        bus.flush = 1'b1;
      end
      wait_valid(12, lat);
      chk($sformatf("vec%0d_word", i), s_word, vecs[i].w);
      chk($sformatf("vec%0d_bytes", i), s_bytes, vecs[i].b);
    end
    bus.out_ready = 1'b1;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    q.delete();
    exp_q.delete();
    bus.fifo_empty = 1'b1;
    flush_seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2) == 0 && q.size() < 16) push(8'($urandom));
      bus.out_ready = $urandom_range(3) != 0;
      if ($urandom_range(39) == 0) begin
        bus.flush = 1'b1;
        flush_seen = 1'b1;
      end
      rnd_cycle();
    end
    bus.out_ready = 1'b1;
    repeat (40) rnd_cycle();
    bus.flush = 1'b1;
    flush_seen = 1'b1;
    repeat (20) rnd_cycle();
    chk("rnd_all_bytes_delivered", exp_q.size(), 0);
    chk("no_read_while_empty", rd_empty_err, 0);
    chk("word_stable_while_held", stab_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
